fp_addsub_seq: RTL and testbench
================================

FP_ADDSUB_SEQ -- requirements
Module: fp_addsub_seq

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk, input, 1, single clock; all state changes on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port A, input, W, operand A (sign|exponent|mantissa, IEEE-754 layout).
REQ-006 SHALL have port B, input, W, operand B.
REQ-007 SHALL have port op, input, 1, 0 = A+B, 1 = A-B.
REQ-008 SHALL have port in_valid, input, 1, operands and op valid.
REQ-009 SHALL have port in_ready, output, 1, block can accept operands.
REQ-010 SHALL have port result, output, W, rounded sum/difference.
REQ-011 SHALL have port flags, output, 4, {invalid, overflow, underflow, inexact}.
REQ-012 SHALL have port out_valid, output, 1, result and flags valid.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.

Function
REQ-014 SHALL implement FSM IDLE, ALIGN, ADD, NORM, ROUND, DONE; in_ready=1 only in IDLE, out_valid=1 only in DONE.
REQ-015 SHALL accept on the edge where in_ready and in_valid are both 1, registering A, B, op, and moving IDLE->ALIGN; in_valid=0 keeps IDLE.
REQ-016 SHALL advance ALIGN->ADD->NORM->ROUND->DONE one state per edge unconditionally; out_valid rises exactly 5 edges after the accept edge.
REQ-017 SHALL hold result and flags stable in DONE until the edge with out_ready=1, then go DONE->IDLE; no accept is possible in that same cycle.
REQ-018 SHALL ignore A, B, op, in_valid changes outside IDLE.
REQ-019 ALIGN: effective B sign = B.sign XOR op; operand with larger magnitude first; smaller mantissa right-shifted by exponent difference, with guard, round, sticky bits kept; shift >= MAN_W+3 collapses into sticky.
REQ-020 ADD: add magnitudes if effective signs match, else subtract smaller from larger; result sign = sign of larger operand.
REQ-021 NORM: carry-out shifts right 1 and increments exponent; otherwise left shift by leading-zero count in one cycle, decrementing exponent.
REQ-022 ROUND: round-to-nearest, ties-to-even, on guard/round/sticky; rounding carry renormalises; inexact=1 when any discarded bit nonzero.
REQ-023 SHALL flush subnormal inputs to signed zero (FTZ) before ALIGN.
REQ-024 SHALL force result to signed zero with underflow=1 and inexact=1 when the final exponent falls below 1.
REQ-025 SHALL force result to signed infinity with overflow=1 and inexact=1 when the final exponent reaches all-ones.
REQ-026 SHALL return canonical qNaN (sign 0, exponent all-ones, mantissa MSB 1, rest 0) with invalid=1 for any NaN input or for inf minus inf after effective sign; other flags 0.
REQ-027 SHALL return the infinity with its effective sign, flags 0, when exactly one operand is infinite.
REQ-028 SHALL return +0 for an exact zero result of opposite-sign operands; for both operands zero, sign = AND of effective signs.

Reset
REQ-029 On rst_n=0, asynchronously: state=IDLE, result=0, flags=0, out_valid=0, in_ready=1, internal registers cleared.
REQ-030 Reset asserted in any state SHALL abort the operation without emitting a result; the first accept after release starts a fresh operation.

Verification (EXP_W=8, MAN_W=23)
REQ-031 A=0x3FC00000, B=0x40100000, op=0, out_ready=1 -> out_valid 5 edges after accept, result=0x40700000, flags=0000.
REQ-032 A=0x40A00000, B=0x40400000, op=1 -> result=0x40000000, flags=0000; same A,B with op=0 -> 0x41000000.
REQ-033 A=0x3F800000, B=0x33800000, op=0 -> result=0x3F800000 (tie to even), flags=0001; A=0x3F800000, B=0x3F800000, op=1 -> 0x00000000, flags=0000.
REQ-034 A=0x7F7FFFFF, B=0x7F7FFFFF, op=0 -> result=0x7F800000, flags=0101; A=0x7F800000, B=0x7F800000, op=1 -> 0x7FC00000, flags=1000.
REQ-035 Hold out_ready=0 for 10 cycles in DONE -> result, flags, out_valid stable, in_ready=0, new in_valid ignored; out_ready=1 -> IDLE next edge.
REQ-036 Assert rst_n=0 while in NORM -> out_valid=0, in_ready=1 immediately; no stale result appears after release.

Source files
------------

// File: rtl/fp_addsub_seq_if.sv
// Operand/result handshake bundle for fp_addsub_seq.
//   master: drives A, B, op, in_valid, out_ready; observes in_ready, result, flags, out_valid
//   slave : the adder side of the same signals
interface fp_addsub_seq_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  localparam int unsigned W = 1 + EXP_W + MAN_W;

  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         op;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         out_valid;
  logic         out_ready;

  modport master (
    output A, B, op, in_valid, out_ready,
    input  in_ready, result, flags, out_valid
  );

  modport slave (
    input  A, B, op, in_valid, out_ready,
    output in_ready, result, flags, out_valid
  );
endinterface

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 style adder/subtractor (FTZ, round-to-nearest-even).
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   io (slave) : A, B, op (0 add, 1 sub), in_valid/in_ready accept handshake,
//                result, flags {invalid, overflow, underflow, inexact},
//                out_valid/out_ready result handshake
// One operation in flight: IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE.
module fp_addsub_seq #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic           clk,
  input logic           rst_n,
  fp_addsub_seq_if.slave io
);
  localparam int unsigned W   = 1 + EXP_W + MAN_W;
  localparam int unsigned FW  = MAN_W + 4;        // hidden + mantissa + guard/round/sticky
  localparam int unsigned XW  = EXP_W + 2;        // signed working exponent
  localparam int unsigned LZW = $clog2(FW) + 1;
  localparam logic [EXP_W-1:0]        EXP_ONES = '1;
  localparam logic signed [XW-1:0]    XONE     = XW'(1);
  localparam logic signed [XW-1:0]    XMAX     = XW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND, DONE} state_t;

  state_t state_q, state_d;
  logic   in_ready_d, out_valid_d;

  logic [W-1:0]           a_q, b_q;
  logic                   op_q;
  logic                   spec_q, spec_inv_q;
  logic [W-1:0]           spec_res_q;
  logic                   sign_q, sub_q, zsign_q, zero_q;
  logic signed [XW-1:0]   exp_q;
  logic [FW-1:0]          man_l_q, man_s_q, nman_q;
  logic [FW:0]            sum_q;

  // Unpack, flush subnormals, classify specials, order by magnitude and align
  logic                 sa, sb, a_nan, b_nan, a_inf, b_inf, a_big, sl;
  logic [EXP_W-1:0]     ea, eb, el, es, diff;
  logic [MAN_W-1:0]     fa, fb;
  logic [MAN_W:0]       ma, mb, ml, ms;
  logic [FW-1:0]        ms_ext, ms_al;
  logic                 sp, sp_inv;
  logic [W-1:0]         sp_res;

  always_comb begin
    sa     = a_q[W-1];
    sb     = b_q[W-1] ^ op_q;
    ea     = a_q[MAN_W +: EXP_W];
    eb     = b_q[MAN_W +: EXP_W];
    fa     = a_q[MAN_W-1:0];
    fb     = b_q[MAN_W-1:0];
    ma     = (ea == '0) ? '0 : {1'b1, fa};
    mb     = (eb == '0) ? '0 : {1'b1, fb};
    a_nan  = (ea == EXP_ONES) && (fa != '0);
    b_nan  = (eb == EXP_ONES) && (fb != '0);
    a_inf  = (ea == EXP_ONES) && (fa == '0);
    b_inf  = (eb == EXP_ONES) && (fb == '0);
    a_big  = {ea, ma} >= {eb, mb};
    sl     = a_big ? sa : sb;
    el     = a_big ? ea : eb;
    es     = a_big ? eb : ea;
    ml     = a_big ? ma : mb;
    ms     = a_big ? mb : ma;
    diff   = el - es;
    ms_ext = {ms, 3'b000};
    if (32'(diff) >= FW - 1) begin
      ms_al = {{(FW-1){1'b0}}, |ms};
    end else begin
      ms_al = (ms_ext >> diff) | FW'(|(ms_ext & ~({FW{1'b1}} << diff)));
    end
    sp     = a_nan | b_nan | a_inf | b_inf;
    sp_inv = a_nan | b_nan | (a_inf & b_inf & (sa != sb));
    if (sp_inv)     sp_res = QNAN;
    else if (a_inf) sp_res = {sa, EXP_ONES, {MAN_W{1'b0}}};
    else            sp_res = {sb, EXP_ONES, {MAN_W{1'b0}}};
  end

  // Normalise: carry-out shifts right (sticky preserved), else one-cycle left shift by lzc
  logic [LZW-1:0]       lz;
  logic [FW-1:0]        n_man;
  logic signed [XW-1:0] n_exp;

  always_comb begin
    lz = '0;
    for (int i = 0; i < FW; i++) begin
      if (sum_q[i]) lz = LZW'(FW - 1 - i);
    end
    if (sum_q[FW]) begin
      n_man = {sum_q[FW:2], sum_q[1] | sum_q[0]};
      n_exp = exp_q + XW'(1);
    end else begin
      n_man = sum_q[FW-1:0] << lz;
      n_exp = exp_q - XW'(lz);
    end
  end

  // Round to nearest even, renormalise on carry, then range-check the exponent
  logic                 g, r, s, rup, inexact;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     frac;
  logic signed [XW-1:0] fe;
  logic [W-1:0]         r_res;
  logic [3:0]           r_flags;

  always_comb begin
    g       = nman_q[2];
    r       = nman_q[1];
    s       = nman_q[0];
    inexact = g | r | s;
    rup     = g & (r | s | nman_q[3]);
    rnd     = {1'b0, nman_q[FW-1:3]} + (MAN_W+2)'(rup);
    if (rnd[MAN_W+1]) begin
      frac = rnd[MAN_W:1];
      fe   = exp_q + XW'(1);
    end else begin
      frac = rnd[MAN_W-1:0];
      fe   = exp_q;
    end
    if (spec_q) begin
      r_res   = spec_res_q;
      r_flags = {spec_inv_q, 3'b000};
    end else if (zero_q) begin
      r_res   = {zsign_q, {(W-1){1'b0}}};
      r_flags = 4'b0000;
    end else if (fe < XONE) begin
      r_res   = {sign_q, {(W-1){1'b0}}};
      r_flags = 4'b0011;
    end else if (fe >= XMAX) begin
      r_res   = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      r_flags = 4'b0101;
    end else begin
      r_res   = {sign_q, fe[EXP_W-1:0], frac};
      r_flags = {3'b000, inexact};
    end
  end

  // State register and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      io.in_ready  <= 1'b1;
      io.out_valid <= 1'b0;
    end else begin
      state_q      <= state_d;
      io.in_ready  <= in_ready_d;
      io.out_valid <= out_valid_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    case (state_q)
      IDLE:    if (io.in_valid) state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // Datapath: each stage captures its own results on leaving its state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      spec_q     <= 1'b0;
      spec_inv_q <= 1'b0;
      spec_res_q <= '0;
      sign_q     <= 1'b0;
      sub_q      <= 1'b0;
      zsign_q    <= 1'b0;
      zero_q     <= 1'b0;
      exp_q      <= '0;
      man_l_q    <= '0;
      man_s_q    <= '0;
      sum_q      <= '0;
      nman_q     <= '0;
      io.result  <= '0;
      io.flags   <= '0;
    end else begin
      case (state_q)
        IDLE: if (io.in_valid) begin
          a_q  <= io.A;
          b_q  <= io.B;
          op_q <= io.op;
        end
        ALIGN: begin
          spec_q     <= sp;
          spec_inv_q <= sp_inv;
          spec_res_q <= sp_res;
          sign_q     <= sl;
          sub_q      <= (sa != sb);
          zsign_q    <= sa & sb;
          exp_q      <= XW'(el);
          man_l_q    <= {ml, 3'b000};
          man_s_q    <= ms_al;
        end
        ADD: begin
          sum_q <= sub_q ? ({1'b0, man_l_q} - {1'b0, man_s_q})
                         : ({1'b0, man_l_q} + {1'b0, man_s_q});
        end
        NORM: begin
          nman_q <= n_man;
          exp_q  <= n_exp;
          zero_q <= (sum_q == '0);
        end
        ROUND: begin
          io.result <= r_res;
          io.flags  <= r_flags;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq (single precision): vector table plus
// back-pressure and mid-operation reset sequences.
module tb_fp_addsub_seq;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned MAN_W = 23;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp_addsub_seq_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) io ();
  fp_addsub_seq #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
    logic [31:0] res;
    logic [3:0]  flg;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation; lat counts edges from the accept edge (inclusive) to out_valid
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                       output logic [31:0] r, output logic [3:0] f, output int lat);
    @(negedge clk);
    io.A = a; io.B = b; io.op = o; io.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    lat = 1;
    while (!io.out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = io.result;
    f = io.flags;
  endtask

  initial begin
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    logic        stable, seen;

    vecs.push_back('{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 4'b0000}); // 1.5+2.25
    vecs.push_back('{32'h40A00000, 32'h40400000, 1'b1, 32'h40000000, 4'b0000}); // 5-3
    vecs.push_back('{32'h40A00000, 32'h40400000, 1'b0, 32'h41000000, 4'b0000}); // 5+3
    vecs.push_back('{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001}); // tie, even stays
    vecs.push_back('{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000}); // exact zero
    vecs.push_back('{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101}); // overflow
    vecs.push_back('{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000}); // inf-inf
    vecs.push_back('{32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000}); // NaN in
    vecs.push_back('{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000}); // inf+1
    vecs.push_back('{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 4'b0000}); // 1-inf
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000}); // -0 + -0
    vecs.push_back('{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000}); // -0 - +0
    vecs.push_back('{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000}); // +0 + -0
    vecs.push_back('{32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000}); // subnormal FTZ
    vecs.push_back('{32'h00800000, 32'h00800001, 1'b1, 32'h80000000, 4'b0011}); // underflow
    vecs.push_back('{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001}); // tie, odd rounds up
    vecs.push_back('{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'b0001}); // above half
    vecs.push_back('{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001}); // rounding carry
    vecs.push_back('{32'h3FFFFFFF, 32'h34000000, 1'b0, 32'h40000000, 4'b0000}); // add carry-out
    vecs.push_back('{32'h3F800000, 32'h3F000000, 1'b1, 32'h3F000000, 4'b0000}); // 1-0.5
    vecs.push_back('{32'hC0000000, 32'h3F800000, 1'b0, 32'hBF800000, 4'b0000}); // -2+1
    vecs.push_back('{32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'b0001}); // shift into sticky

    io.A = '0; io.B = '0; io.op = 1'b0; io.in_valid = 1'b0; io.out_ready = 1'b1;

    // Reset values
    #12;
    chk("reset in_ready",  32'(io.in_ready),  32'd1);
    chk("reset out_valid", 32'(io.out_valid), 32'd0);
    chk("reset result",    io.result,         32'h0);
    chk("reset flags",     32'(io.flags),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, r, f, lat);
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'd5);
      chk($sformatf("vec%0d result", i), r, vecs[i].res);
      chk($sformatf("vec%0d flags", i), 32'(f), 32'(vecs[i].flg));
    end

    // Back-pressure: hold DONE for 10 cycles while new operands are offered
    @(negedge clk);
    io.out_ready = 1'b0;
    do_op(32'h3FC00000, 32'h40100000, 1'b0, r, f, lat);
    chk("hold latency", 32'(lat), 32'd5);
    io.A = 32'h40A00000; io.B = 32'h40400000; io.op = 1'b1; io.in_valid = 1'b1;
    stable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (io.result !== 32'h40700000 || io.flags !== 4'b0000 ||
          io.out_valid !== 1'b1 || io.in_ready !== 1'b0) stable = 1'b0;
    end
    chk("hold stable", 32'(stable), 32'd1);
    io.out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready",  32'(io.in_ready),  32'd1);
    chk("release out_valid", 32'(io.out_valid), 32'd0);
    io.in_valid = 1'b0;
    // Nothing was accepted on the release edge, so no result may follow
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (io.out_valid) seen = 1'b1;
    end
    chk("release no accept", 32'(seen), 32'd0);

    // Reset while in NORM aborts the operation
    @(negedge clk);
    io.A = 32'h40A00000; io.B = 32'h40400000; io.op = 1'b0; io.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", 32'(io.out_valid), 32'd0);
    chk("abort in_ready",  32'(io.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (io.out_valid) seen = 1'b1;
    end
    chk("abort no stale", 32'(seen), 32'd0);
    do_op(32'h40A00000, 32'h40400000, 1'b1, r, f, lat);
    chk("fresh latency", 32'(lat), 32'd5);
    chk("fresh result", r, 32'h40000000);
    chk("fresh flags", 32'(f), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
